// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes, funct codes, CP0 indices, address map and store-lane helper for mips_core.
// Optional feature macro: MIPS_INT_EN (interrupt logic, used by mips_cp0 and mips_core).
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_COP0  = 6'h10;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ERET  = 6'h18;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [4:0] COP_MF   = 5'h00;
    localparam logic [4:0] COP_MT   = 5'h04;
    localparam logic [4:0] COP_CO   = 5'h10;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;

    localparam logic [31:0] RESET_PC     = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC   = 32'h0000_4180;
    localparam logic [31:0] DATA_LIMIT   = 32'h0000_3000;
    localparam logic [31:0] INT_ACK_BASE = 32'h0000_7F20;
    // SR keeps only IM[15:10], EXL[1] and IE[0]; every other bit reads 0.
    localparam logic [31:0] SR_MASK      = 32'h0000_FC03;

    typedef enum logic [1:0] {ST_NONE, ST_WORD, ST_HALF, ST_BYTE} store_e;

    function automatic logic [3:0] lane_en(input store_e k, input logic [1:0] a);
        return (k == ST_WORD) ? 4'b1111 :
               (k == ST_HALF) ? (a[1] ? 4'b1100 : 4'b0011) :
               (k == ST_BYTE) ? (4'b0001 << a) : 4'b0000;
    endfunction

endpackage

// File: rtl/mips_cp0.sv
// mips_cp0: SR/Cause/EPC registers, interrupt-take decision, EPC output for eret.
// Ports: clk, reset (async active-low), interrupt (HWInt[2]), we/idx/wdata (mtc0 write, mfc0 read index),
//        eret (decoded eret), pc (current PC), rdata (mfc0 data), epc, int_take, eret_take.
// Feature macro: MIPS_INT_EN; when undefined the block reads 0 and never takes or returns.
module mips_cp0
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        interrupt,
    input  logic        we,
    input  logic        eret,
    input  logic [4:0]  idx,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic [31:0] rdata,
    output logic [31:0] epc,
    output logic        int_take,
    output logic        eret_take
);
`ifdef MIPS_INT_EN
    logic [31:0] sr_q, sr_d, epc_q, epc_d;
    logic        ip_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q  <= '0;
            epc_q <= '0;
            ip_q  <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            epc_q <= epc_d;
            ip_q  <= interrupt;
        end
    end

    // Decision uses the registered SR, so an mtc0 in the same cycle cannot affect it.
    always_comb begin
        int_take  = interrupt & sr_q[12] & sr_q[0] & ~sr_q[1];
        eret_take = eret & ~int_take;
        sr_d      = sr_q;
        epc_d     = epc_q;
        if (int_take) begin
            epc_d    = pc;
            sr_d[1]  = 1'b1;
        end else if (eret) begin
            sr_d[1]  = 1'b0;
        end else if (we && idx == CP0_SR) begin
            sr_d     = wdata & SR_MASK;
        end else if (we && idx == CP0_EPC) begin
            epc_d    = wdata;
        end
    end

    assign rdata = (idx == CP0_SR)    ? sr_q :
                   (idx == CP0_CAUSE) ? {19'b0, ip_q, 12'b0} :
                   (idx == CP0_EPC)   ? epc_q : 32'h0;
    assign epc   = epc_q;
`else
    logic unused_cp0;
    assign unused_cp0 = ^{clk, reset, interrupt, we, eret, idx, wdata, pc};
    assign rdata      = 32'h0;
    assign epc        = 32'h0;
    assign int_take   = 1'b0;
    assign eret_take  = 1'b0;
`endif
endmodule

// File: rtl/mips_core.sv
// mips_core: single-cycle MIPS-subset CPU with external interrupt, commit trace outputs.
// Ports: clk, reset (async active-low), interrupt; fetch i_inst_addr/i_inst_rdata;
//        data bus m_data_addr/rdata/wdata/byteen; interrupt-ack m_int_addr/byteen; m_inst_addr;
//        trace w_grf_we/addr/wdata/w_inst_addr; macroscopic_pc.
// Feature macro: MIPS_INT_EN enables interrupts, CP0 Cause/EPC and 0x7F20 store routing.
module mips_core
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        interrupt,
    output logic [31:0] macroscopic_pc,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] m_data_addr,
    input  logic [31:0] m_data_rdata,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    output logic [31:0] m_int_addr,
    output logic [3:0]  m_int_byteen,
    output logic [31:0] m_inst_addr,
    output logic        w_grf_we,
    output logic [4:0]  w_grf_addr,
    output logic [31:0] w_grf_wdata,
    output logic [31:0] w_inst_addr
);
    logic [31:0] pc_q, pc_d;
    logic [31:0] grf_q [32];
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, waddr;
    logic [31:0] rs_v, rt_v, imm_s, imm_z, pc_4, alu, npc, wdata;
    logic [31:0] cp0_rdata, epc;
    logic        we, cp0_we, cp0_eret, int_take, eret_take, commit;
    logic [3:0]  lanes;
    store_e      st;

    assign op    = i_inst_rdata[31:26];
    assign rs    = i_inst_rdata[25:21];
    assign rt    = i_inst_rdata[20:16];
    assign rd    = i_inst_rdata[15:11];
    assign fn    = i_inst_rdata[5:0];
    assign rs_v  = grf_q[rs];
    assign rt_v  = grf_q[rt];
    assign imm_s = {{16{i_inst_rdata[15]}}, i_inst_rdata[15:0]};
    assign imm_z = {16'h0, i_inst_rdata[15:0]};
    assign pc_4  = pc_q + 32'd4;

    mips_cp0 u_cp0 (
        .clk       (clk),
        .reset     (reset),
        .interrupt (interrupt),
        .we        (cp0_we),
        .eret      (cp0_eret),
        .idx       (rd),
        .wdata     (rt_v),
        .pc        (pc_q),
        .rdata     (cp0_rdata),
        .epc       (epc),
        .int_take  (int_take),
        .eret_take (eret_take)
    );

    // alu defaults to the load/store address so memory ops need no extra case.
    always_comb begin
        alu      = rs_v + imm_s;
        we       = 1'b0;
        waddr    = rd;
        npc      = pc_4;
        st       = ST_NONE;
        cp0_we   = 1'b0;
        cp0_eret = 1'b0;
        case (op)
            OP_RTYPE: case (fn)
                FN_ADDU: begin we = 1'b1; alu = rs_v + rt_v; end
                FN_SUBU: begin we = 1'b1; alu = rs_v - rt_v; end
                FN_AND:  begin we = 1'b1; alu = rs_v & rt_v; end
                FN_OR:   begin we = 1'b1; alu = rs_v | rt_v; end
                FN_SLT:  begin we = 1'b1; alu = {31'h0, $signed(rs_v) < $signed(rt_v)}; end
                FN_JR:   npc = rs_v;
                default: ;
            endcase
            OP_ORI:   begin we = 1'b1; waddr = rt; alu = rs_v | imm_z; end
            OP_LUI:   begin we = 1'b1; waddr = rt; alu = {i_inst_rdata[15:0], 16'h0}; end
            OP_ADDIU: begin we = 1'b1; waddr = rt; end
            OP_LW:    begin we = 1'b1; waddr = rt; end
            OP_SW:    st = ST_WORD;
            OP_SH:    st = ST_HALF;
            OP_SB:    st = ST_BYTE;
            OP_BEQ:   npc = (rs_v == rt_v) ? pc_4 + {imm_s[29:0], 2'b00} : pc_4;
            OP_BNE:   npc = (rs_v != rt_v) ? pc_4 + {imm_s[29:0], 2'b00} : pc_4;
            OP_J:     npc = {pc_4[31:28], i_inst_rdata[25:0], 2'b00};
            OP_JAL:   begin npc = {pc_4[31:28], i_inst_rdata[25:0], 2'b00}; we = 1'b1; waddr = 5'd31; end
            OP_COP0:  case (rs)
                COP_MF:  begin we = 1'b1; waddr = rt; end
                COP_MT:  cp0_we = 1'b1;
                COP_CO:  cp0_eret = (fn == FN_ERET);
                default: ;
            endcase
            default: ;
        endcase
        wdata = (op == OP_LW)   ? m_data_rdata :
                (op == OP_JAL)  ? pc_4 :
                (op == OP_COP0) ? cp0_rdata : alu;
        pc_d  = int_take ? HANDLER_PC : eret_take ? epc : npc;
    end

    // Nothing commits while reset is held or when the interrupt squashes this instruction.
    assign commit         = reset & ~int_take;
    assign lanes          = lane_en(st, alu[1:0]);
    assign m_data_byteen  = (commit && alu < DATA_LIMIT) ? lanes : 4'b0000;
`ifdef MIPS_INT_EN
    assign m_int_byteen   = (commit && alu[31:2] == INT_ACK_BASE[31:2]) ? lanes : 4'b0000;
`else
    assign m_int_byteen   = 4'b0000;
`endif
    assign m_data_wdata   = (st == ST_HALF) ? {2{rt_v[15:0]}} :
                            (st == ST_BYTE) ? {4{rt_v[7:0]}} : rt_v;
    assign m_data_addr    = alu;
    assign m_int_addr     = alu;
    assign w_grf_we       = commit & we;
    assign w_grf_addr     = waddr;
    assign w_grf_wdata    = wdata;
    assign macroscopic_pc = pc_q;
    assign i_inst_addr    = pc_q;
    assign m_inst_addr    = pc_q;
    assign w_inst_addr    = pc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
            for (int i = 0; i < 32; i++) grf_q[i] <= '0;
        end else begin
            pc_q <= pc_d;
            if (w_grf_we && w_grf_addr != 5'd0) grf_q[w_grf_addr] <= w_grf_wdata;
        end
    end
endmodule

// File: tb/tb_mips_core.sv
// tb_mips_core: randomized instruction stream against an instruction-level reference model, scoreboarded.
module tb_mips_core;
`ifdef MIPS_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [3:0]  db;
        logic [3:0]  ib;
        logic [31:0] addr;
        logic [31:0] sd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, interrupt;
    logic [31:0] macroscopic_pc, i_inst_addr, i_inst_rdata, m_data_addr, m_data_rdata, m_data_wdata;
    logic [31:0] m_int_addr, m_inst_addr, w_grf_wdata, w_inst_addr;
    logic [3:0]  m_data_byteen, m_int_byteen;
    logic        w_grf_we;
    logic [4:0]  w_grf_addr;

    int checks = 0;
    int failures = 0;
    exp_t q[$];
    exp_t me;
    logic [31:0] imem [logic [31:0]];

    logic [31:0] m_pc, m_sr, m_epc;
    logic [31:0] m_reg [32];
    logic        m_ip;

    always #5 clk = ~clk;

    mips_core dut (
        .clk            (clk),
        .reset          (reset),
        .interrupt      (interrupt),
        .macroscopic_pc (macroscopic_pc),
        .i_inst_addr    (i_inst_addr),
        .i_inst_rdata   (i_inst_rdata),
        .m_data_addr    (m_data_addr),
        .m_data_rdata   (m_data_rdata),
        .m_data_wdata   (m_data_wdata),
        .m_data_byteen  (m_data_byteen),
        .m_int_addr     (m_int_addr),
        .m_int_byteen   (m_int_byteen),
        .m_inst_addr    (m_inst_addr),
        .w_grf_we       (w_grf_we),
        .w_grf_addr     (w_grf_addr),
        .w_grf_wdata    (w_grf_wdata),
        .w_inst_addr    (w_inst_addr)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s at t=%0t got=%h expected=%h", name, $time, got, want);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h3000; m_sr = 0; m_epc = 0; m_ip = 0;
        for (int i = 0; i < 32; i++) m_reg[i] = 0;
    endtask

    function automatic logic [31:0] gen();
        logic [4:0]  s = 5'($urandom_range(0, 7));
        logic [4:0]  t = 5'($urandom_range(0, 7));
        logic [4:0]  d = 5'($urandom_range(0, 7));
        logic [15:0] im = 16'($urandom);
        logic [4:0]  cr = 5'($urandom_range(11, 15));
        logic [15:0] sa;
        int          o = int'($urandom_range(0, 8)) - 4;
        logic [31:0] tg = (32'h3000 + ($urandom_range(0, 1023) << 2)) >> 2;
        case ($urandom_range(0, 2))
            0:       sa = 16'($urandom_range(0, 32'h2FFF));
            1:       sa = 16'(32'h7F20 + $urandom_range(0, 3));
            default: sa = 16'(32'h5000 + $urandom_range(0, 32'hFFF));
        endcase
        case ($urandom_range(0, 21))
            0:  return {6'h00, s, t, d, 5'h0, 6'h21};
            1:  return {6'h00, s, t, d, 5'h0, 6'h23};
            2:  return {6'h00, s, t, d, 5'h0, 6'h24};
            3:  return {6'h00, s, t, d, 5'h0, 6'h25};
            4:  return {6'h00, s, t, d, 5'h0, 6'h2A};
            5:  return {6'h00, 5'd31, 15'h0, 6'h08};
            6:  return {6'h0D, s, t, im};
            7:  return {6'h0F, 5'd0, t, im};
            8:  return {6'h09, s, t, im};
            9:  return {6'h23, 5'd0, t, 16'($urandom_range(0, 32'h2FFF))};
            10: return {6'h2B, 5'd0, t, sa};
            11: return {6'h29, 5'd0, t, sa};
            12: return {6'h28, 5'd0, t, sa};
            13: return {6'h04, s, t, 16'(o)};
            14: return {6'h05, s, t, 16'(o)};
            15: return {6'h02, tg[25:0]};
            16: return {6'h03, tg[25:0]};
            17: return {6'h10, 5'd0, t, cr, 11'h0};
            18: return {6'h10, 5'd4, s, cr, 11'h0};
            19: return 32'h4200_0018;
            20: return {6'h3F, 26'($urandom)};
            default: return {6'h00, s, t, d, 5'h0, 6'h3E};
        endcase
    endfunction

    // Reference model: executes one instruction per call and reports the expected commit.
    task automatic step(input logic [31:0] ins, input logic intr, input logic [31:0] ld, output exp_t e);
        logic [5:0]  op = ins[31:26], fn = ins[5:0];
        logic [4:0]  s = ins[25:21], t = ins[20:16], d = ins[15:11], wa = 0;
        logic [31:0] a = m_reg[ins[25:21]], b = m_reg[ins[20:16]];
        logic [31:0] si = {{16{ins[15]}}, ins[15:0]};
        logic [31:0] nx = m_pc + 4, ad, res = 0, sd = 0;
        logic [3:0]  be = 0;
        logic        wr = 0;
        ad = a + si;
        e = '{pc: m_pc, we: 0, wa: 0, wd: 0, db: 0, ib: 0, addr: 0, sd: 0};
        if (INT_EN && intr && m_sr[12] && m_sr[0] && !m_sr[1]) begin
            m_epc = m_pc; m_sr[1] = 1'b1; m_pc = 32'h4180; m_ip = intr;
            return;
        end
        case (op)
            6'h00: case (fn)
                6'h21: begin wr = 1; wa = d; res = a + b; end
                6'h23: begin wr = 1; wa = d; res = a - b; end
                6'h24: begin wr = 1; wa = d; res = a & b; end
                6'h25: begin wr = 1; wa = d; res = a | b; end
                6'h2A: begin wr = 1; wa = d; res = ($signed(a) < $signed(b)) ? 1 : 0; end
                6'h08: nx = a;
                default: ;
            endcase
            6'h0D: begin wr = 1; wa = t; res = a | {16'h0, ins[15:0]}; end
            6'h0F: begin wr = 1; wa = t; res = {ins[15:0], 16'h0}; end
            6'h09: begin wr = 1; wa = t; res = a + si; end
            6'h23: begin wr = 1; wa = t; res = ld; end
            6'h2B: begin be = 4'b1111; sd = b; end
            6'h29: begin be = ad[1] ? 4'b1100 : 4'b0011; sd = {b[15:0], b[15:0]}; end
            6'h28: begin be = 4'b0001 << ad[1:0]; sd = {b[7:0], b[7:0], b[7:0], b[7:0]}; end
            6'h04: if (a == b) nx = m_pc + 4 + (si << 2);
            6'h05: if (a != b) nx = m_pc + 4 + (si << 2);
            6'h02: nx = {nx[31:28], ins[25:0], 2'b00};
            6'h03: begin wr = 1; wa = 31; res = m_pc + 4; nx = {nx[31:28], ins[25:0], 2'b00}; end
            6'h10: begin
                if (s == 0) begin
                    wr = 1; wa = t;
                    res = !INT_EN ? 0 : d == 12 ? m_sr : d == 13 ? (m_ip ? 32'h1000 : 0) : d == 14 ? m_epc : 0;
                end else if (s == 4 && INT_EN) begin
                    if (d == 12) m_sr = b & 32'hFC03;
                    else if (d == 14) m_epc = b;
                end else if (s == 5'h10 && fn == 6'h18 && INT_EN) begin
                    nx = m_epc; m_sr[1] = 1'b0;
                end
            end
            default: ;
        endcase
        if (be != 0) begin
            e.addr = ad; e.sd = sd;
            if (ad < 32'h3000) e.db = be;
            else if (INT_EN && ad >= 32'h7F20 && ad <= 32'h7F23) e.ib = be;
        end
        e.we = wr; e.wa = wa; e.wd = res;
        if (wr && wa != 0) m_reg[wa] = res;
        m_pc = nx; m_ip = intr;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                me = q.pop_front();
                chk("macroscopic_pc", macroscopic_pc, me.pc);
                chk("i_inst_addr", i_inst_addr, me.pc);
                chk("m_inst_addr", m_inst_addr, me.pc);
                chk("w_inst_addr", w_inst_addr, me.pc);
                chk("w_grf_we", 32'(w_grf_we), 32'(me.we));
                if (me.we) begin
                    chk("w_grf_addr", 32'(w_grf_addr), 32'(me.wa));
                    chk("w_grf_wdata", w_grf_wdata, me.wd);
                end
                chk("m_data_byteen", 32'(m_data_byteen), 32'(me.db));
                chk("m_int_byteen", 32'(m_int_byteen), 32'(me.ib));
                if (me.db != 0 || me.ib != 0) begin
                    chk("m_data_addr", m_data_addr, me.addr);
                    chk("m_int_addr", m_int_addr, me.addr);
                    chk("m_data_wdata", m_data_wdata, me.sd);
                end
            end
        end
    end

    initial begin
        logic        intr, dir, fa;
        logic [31:0] ins, rdv;
        exp_t        e;
        dir = 1; fa = 0;
        reset = 0; interrupt = 0; i_inst_rdata = 0; m_data_rdata = 0;
        imem[32'h3000] = 32'h3401_1234;
        imem[32'h3004] = 32'hAC01_0004;
        imem[32'h3008] = 32'h3403_1001;
        imem[32'h300C] = 32'hA001_0001;
        imem[32'h3010] = 32'h1000_0002;
        imem[32'h3014] = 32'h0;
        imem[32'h3018] = 32'h0;
        imem[32'h301C] = 32'h4083_6000;
        imem[32'h3020] = 32'h3404_0055;
        imem[32'h3024] = 32'h0C00_0C40;
        imem[32'h4180] = 32'h4005_7000;
        imem[32'h4184] = 32'hAC01_7F20;
        imem[32'h4188] = 32'h3407_0001;
        imem[32'h418C] = 32'h4200_0018;
        model_reset();
        repeat (2) @(negedge clk);
        i_inst_rdata = 32'hAC01_0004;
        #1;
        chk("reset_we", 32'(w_grf_we), 32'h0);
        chk("reset_data_byteen", 32'(m_data_byteen), 32'h0);
        chk("reset_int_byteen", 32'(m_int_byteen), 32'h0);
        chk("reset_pc", macroscopic_pc, 32'h3000);
        chk("reset_i_addr", i_inst_addr, 32'h3000);
        chk("reset_w_inst", w_inst_addr, 32'h3000);
        @(negedge clk);
        reset = 1;
        for (int c = 0; c < 4000; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 2000) begin
                i_inst_rdata = 32'h3401_1234;
                #1 reset = 0;
                #1;
                chk("midreset_we", 32'(w_grf_we), 32'h0);
                chk("midreset_byteen", 32'(m_data_byteen), 32'h0);
                chk("midreset_pc", macroscopic_pc, 32'h3000);
                @(negedge clk);
                reset = 1;
                model_reset();
            end
            if (dir) begin
                intr = 0;
                if (m_pc == 32'h3020 && !fa) begin intr = 1; fa = 1; end
                if (m_pc == 32'h4188) intr = 1;
                if (m_pc == 32'h3024) dir = 0;
            end else begin
                intr = ($urandom_range(0, 3) == 0);
            end
            rdv = $urandom;
            if (!imem.exists(m_pc)) imem[m_pc] = gen();
            ins = imem[m_pc];
            interrupt = intr; m_data_rdata = rdv; i_inst_rdata = ins;
            step(ins, intr, rdv, e);
            q.push_back(e);
        end
        repeat (2) @(negedge clk);
        #3;
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
